shift_clamp_pipe: RTL and testbench

SHIFT_CLAMP_PIPE -- requirements
Module: shift_clamp_pipe

---
 rtl/shift_clamp_pipe.sv | 157 +++++++++++++++
 tb/tb_shift_clamp_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_clamp_pipe.sv
// shift_clamp_pipe: per-lane unsigned clamp of shift amounts to LIMIT, carried
// through a two-stage elastic pipe, plus a saturating count of clamped lanes.

// One lane: S1 holds the raw amount and its >= LIMIT flag, S2 holds the result.
module scp_lane #(
  parameter int W     = 8,
  parameter int LIMIT = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s1_ld_i,
  input  logic         s2_ld_i,
  input  logic         s1_byp_i,
  input  logic [W-1:0] shift_i,
  output logic [W-1:0] shift_o,
  output logic         ge_o
);
  logic [W-1:0] s1_shift_q, s2_shift_q, res_d;
  logic         s1_ge_q, s2_ge_q;

  // Clamp only when the beat is not bypassed and the raw amount reached LIMIT.
  always_comb begin
    res_d = s1_shift_q;
    if (!s1_byp_i && s1_ge_q) res_d = W'(LIMIT);
  end

  // Stage registers; reset clears data so outputs read zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_shift_q <= '0;
      s1_ge_q    <= 1'b0;
      s2_shift_q <= '0;
      s2_ge_q    <= 1'b0;
    end else begin
      if (s1_ld_i) begin
        s1_shift_q <= shift_i;
        s1_ge_q    <= (shift_i >= W'(LIMIT));
      end
      if (s2_ld_i) begin
        s2_shift_q <= res_d;
        s2_ge_q    <= s1_ge_q;
      end
    end
  end

  assign shift_o = s2_shift_q;
  assign ge_o    = s2_ge_q;
endmodule

module shift_clamp_pipe #(
  parameter int W     = 8,
  parameter int LIMIT = 24,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_shift,
  input  logic                 in_bypass,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_shift,
  output logic [LANES-1:0]     out_ge,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     clamp_cnt
);
  // LIMIT must be representable in a lane; W >= 32 always fits an int LIMIT.
  generate
    if (LANES < 1 || CNT_W < 1 || W < 1 || LIMIT < 0 ||
        (W < 31 && LIMIT >= (1 << W))) begin : g_bad_params
      $error("shift_clamp_pipe: illegal parameter combination");
    end
  endgenerate

  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic s1_byp_q, s2_byp_q;
  logic s1_ld, s2_ld, out_fire;

  // Handshake: S2 drains on out_ready, S1 advances into an empty/draining S2.
  assign out_fire = s2_v_q && out_ready;
  assign s2_ld    = s1_v_q && (!s2_v_q || out_ready);
  assign in_ready = !(s1_v_q && s2_v_q && !out_ready);
  assign s1_ld    = in_valid && in_ready;

  // Valid-bit next state: a load wins over the stage emptying in the same cycle.
  always_comb begin
    s1_v_d = s1_v_q;
    s2_v_d = s2_v_q;
    if (s1_ld)         s1_v_d = 1'b1;
    else if (s2_ld)    s1_v_d = 1'b0;
    if (s2_ld)         s2_v_d = 1'b1;
    else if (out_fire) s2_v_d = 1'b0;
  end

  // Valid bits and the per-beat bypass flag travelling alongside the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s1_byp_q <= 1'b0;
      s2_byp_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      if (s1_ld) s1_byp_q <= in_bypass;
      if (s2_ld) s2_byp_q <= s1_byp_q;
    end
  end

  assign out_valid = s2_v_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    scp_lane #(.W(W), .LIMIT(LIMIT)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .s1_ld_i  (s1_ld),
      .s2_ld_i  (s2_ld),
      .s1_byp_i (s1_byp_q),
      .shift_i  (in_shift[i*W +: W]),
      .shift_o  (out_shift[i*W +: W]),
      .ge_o     (out_ge[i])
    );
  end

  logic [PC_W-1:0]  n_ge;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Number of lanes flagged in the beat currently held in S2.
  always_comb begin
    n_ge = '0;
    for (int i = 0; i < LANES; i++) n_ge = n_ge + PC_W'(out_ge[i]);
  end

  // Saturating add of clamped lanes on transfer; clear takes priority.
  always_comb begin
    sum   = SUM_W'(cnt_q) + SUM_W'(n_ge);
    cnt_d = cnt_q;
    if (clr_cnt)
      cnt_d = '0;
    else if (out_fire && !s2_byp_q)
      cnt_d = (sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  // Clamp-event counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign clamp_cnt = cnt_q;
endmodule

// File: tb/tb_shift_clamp_pipe.sv
// Scoreboard bench for shift_clamp_pipe: default instance plus a CNT_W=3 twin
// sharing the same inputs to exercise counter saturation.
module tb_shift_clamp_pipe;
  localparam int W = 8, LIMIT = 24, LANES = 4;
  localparam int MAX16 = 65535, MAX3 = 7;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_bypass = 1'b0, out_ready = 1'b1, clr_cnt = 1'b0;
  logic [LANES*W-1:0] in_shift = '0;
  logic in_ready, out_valid, in_ready3, out_valid3;
  logic [LANES*W-1:0] out_shift, out_shift3;
  logic [LANES-1:0] out_ge, out_ge3;
  logic [15:0] clamp_cnt;
  logic [2:0] clamp_cnt3;

  always #5 clk = ~clk;

  shift_clamp_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_shift(in_shift), .in_bypass(in_bypass), .out_valid(out_valid),
    .out_ready(out_ready), .out_shift(out_shift), .out_ge(out_ge),
    .clr_cnt(clr_cnt), .clamp_cnt(clamp_cnt));

  shift_clamp_pipe #(.CNT_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .in_shift(in_shift), .in_bypass(in_bypass), .out_valid(out_valid3),
    .out_ready(out_ready), .out_shift(out_shift3), .out_ge(out_ge3),
    .clr_cnt(clr_cnt), .clamp_cnt(clamp_cnt3));

  typedef struct {
    logic [LANES*W-1:0] sh;
    logic [LANES-1:0]   ge;
    int                 n;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0;
  int m_cnt = 0, m_cnt3 = 0;
  logic held = 1'b0;
  logic [LANES*W-1:0] held_sh;
  logic [LANES-1:0] held_ge;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each lane clamps to LIMIT unless bypassed; flag is raw >= LIMIT.
  function automatic exp_t model(input logic [LANES*W-1:0] s, input logic byp);
    exp_t e;
    e.n = 0;
    for (int i = 0; i < LANES; i++) begin
      int v;
      v = int'(s[i*W +: W]);
      e.ge[i] = (v >= LIMIT);
      e.sh[i*W +: W] = (!byp && v >= LIMIT) ? W'(LIMIT) : W'(v);
      if (!byp && v >= LIMIT) e.n++;
    end
    return e;
  endfunction

  function automatic logic [LANES*W-1:0] rand_beat();
    logic [LANES*W-1:0] r;
    for (int i = 0; i < LANES; i++)
      case ($urandom_range(0, 3))
        0: r[i*W +: W] = W'(LIMIT - 1);
        1: r[i*W +: W] = W'(LIMIT);
        2: r[i*W +: W] = {W{1'b1}};
        default: r[i*W +: W] = W'($urandom);
      endcase
    return r;
  endfunction

  // Monitor: checks handshake, counter and stall stability, pops on output
  // transfers and pushes the model result when a beat is accepted.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_cnt = 0; m_cnt3 = 0; held = 1'b0;
    end else begin
      chk("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
      chk("in_ready3", in_ready3, !(sb.size() == 2 && !out_ready));
      chk("clamp_cnt", clamp_cnt, m_cnt);
      chk("clamp_cnt3", clamp_cnt3, m_cnt3);
      if (held) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_shift", out_shift, held_sh);
        chk("stall_ge", out_ge, held_ge);
      end
      held = out_valid && !out_ready;
      held_sh = out_shift;
      held_ge = out_ge;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_beat", out_valid, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_shift", out_shift, e.sh);
          chk("out_ge", out_ge, e.ge);
          chk("out_shift3", out_shift3, e.sh);
          chk("out_valid3", out_valid3, 1);
          if (!clr_cnt) begin
            m_cnt  = (m_cnt + e.n > MAX16) ? MAX16 : m_cnt + e.n;
            m_cnt3 = (m_cnt3 + e.n > MAX3) ? MAX3 : m_cnt3 + e.n;
          end
        end
      end
      if (clr_cnt) begin m_cnt = 0; m_cnt3 = 0; end
      if (in_valid && in_ready) sb.push_back(model(in_shift, in_bypass));
    end
  end

  task automatic send1(input logic [LANES*W-1:0] s, input logic b);
    int t;
    t = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_shift = s; in_bypass = b;
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    chk("send_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    while (sb.size() != 0 && t < 50) begin @(negedge clk); t++; end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic [LANES*W-1:0] beats[10];
    int i, c;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_clamp_cnt", clamp_cnt, 0);
    chk("rst_out_shift", out_shift, 0);
    @(negedge clk); rst_n = 1'b1;

    // Directed boundary beat {0,23,24,255}, clamped then bypassed.
    send1({8'd255, 8'd24, 8'd23, 8'd0}, 1'b0);
    @(negedge clk); chk("lat_s1_empty_out", out_valid, 0);
    @(negedge clk); chk("lat2_valid", out_valid, 1);
    chk("dir_shift", out_shift, 32'h18181700);
    chk("dir_ge", out_ge, 4'b1100);
    @(negedge clk); chk("dir_cnt", clamp_cnt, 2);
    send1({8'd255, 8'd24, 8'd23, 8'd0}, 1'b1);
    @(negedge clk);
    @(negedge clk); chk("byp_valid", out_valid, 1);
    chk("byp_shift", out_shift, 32'hFF181700);
    chk("byp_ge", out_ge, 4'b1100);
    @(negedge clk); chk("byp_cnt", clamp_cnt, 2);

    // Ten back-to-back beats against out_ready pattern 1,0,0,1.
    foreach (beats[k]) beats[k] = rand_beat();
    i = 0; c = 0;
    while (i < 10 && c < 200) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_shift = beats[i]; in_bypass = 1'b0;
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      @(negedge clk);
      if (in_ready) i++;
      c++;
    end
    chk("stream_sent", i, 10);
    drain();

    // Narrow counter: 4, 7, 7, then clear racing an output transfer.
    @(posedge clk); #1; clr_cnt = 1'b1;
    @(posedge clk); #1; clr_cnt = 1'b0;
    repeat (3) send1({4{8'd30}}, 1'b0);
    drain();
    @(negedge clk); chk("cnt3_sat", clamp_cnt3, 7);
    @(posedge clk); #1; out_ready = 1'b0;
    send1({4{8'd30}}, 1'b0);
    repeat (2) @(posedge clk);
    #1; out_ready = 1'b1; clr_cnt = 1'b1;
    @(posedge clk); #1; clr_cnt = 1'b0;
    @(negedge clk); chk("clr_vs_inc3", clamp_cnt3, 0);
    chk("clr_vs_inc", clamp_cnt, 0);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_shift  = rand_beat();
      in_bypass = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_cnt   = ($urandom_range(0, 31) == 0);
    end
    @(posedge clk); #1; clr_cnt = 1'b0;
    drain();

    // Reset with both stages full.
    send1({4{8'd255}}, 1'b0);
    drain();
    @(posedge clk); #1; out_ready = 1'b0;
    send1(rand_beat(), 1'b0);
    send1(rand_beat(), 1'b1);
    @(posedge clk); #1; in_valid = 1'b1; in_shift = rand_beat();
    @(negedge clk); chk("full_in_ready", in_ready, 0);
    @(posedge clk); #2;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_cnt", clamp_cnt, 0);
    chk("async_cnt3", clamp_cnt3, 0);
    chk("async_shift", out_shift, 0);
    chk("async_ge", out_ge, 0);
    chk("async_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (6) begin @(negedge clk); chk("no_stale", out_valid, 0); end
    send1({8'd24, 8'd23, 8'd255, 8'd1}, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
